// File: rtl/mem_fill_arbiter_if.sv
// Bus bundle between the I/D caches, the shared main memory and the fill arbiter.
//
// Handshake semantics: imiss, dmiss and dwrite are level requests. The requester
// holds the request and its address/data stable until its completion pulse
// (fill_done_i, fill_done_d, dwrite_ack) and may drop it on the cycle after the
// pulse. The arbiter samples requests only while idle, so a request raised while
// busy simply waits. mem_en/mem_wr form a one-cycle command with no backpressure;
// mem_rvalid returns read data in issue order after a fixed latency of at least
// one cycle.
`timescale 1ns/1ps
interface mem_fill_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
);
    localparam int WORD_W = $clog2(WORDS);

    // cache-side requests
    logic              imiss;
    logic [ADDR_W-1:0] imiss_addr;
    logic              dmiss;
    logic [ADDR_W-1:0] dmiss_addr;
    logic              dwrite;
    logic [ADDR_W-1:0] dwrite_addr;
    logic [DATA_W-1:0] dwrite_data;

    // main memory port
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    // fill and completion feedback
    logic [DATA_W-1:0] fill_data;
    logic [WORD_W-1:0] fill_word;
    logic              fill_we_i;
    logic              fill_we_d;
    logic              fill_done_i;
    logic              fill_done_d;
    logic              dwrite_ack;
    logic              busy;

    // arbiter side
    modport master (
        input  imiss, imiss_addr, dmiss, dmiss_addr,
        input  dwrite, dwrite_addr, dwrite_data,
        input  mem_rdata, mem_rvalid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, fill_we_i, fill_we_d,
        output fill_done_i, fill_done_d, dwrite_ack, busy
    );

    // caches and memory side
    modport slave (
        output imiss, imiss_addr, dmiss, dmiss_addr,
        output dwrite, dwrite_addr, dwrite_data,
        output mem_rdata, mem_rvalid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, fill_we_i, fill_we_d,
        input  fill_done_i, fill_done_d, dwrite_ack, busy
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shared main-memory arbiter for the I-cache and D-cache. Serves write-through
// stores (one cycle) and block fills (WORDS reads, returns counted regardless of
// memory latency). Priority when idle: store > D miss > I miss.
`timescale 1ns/1ps
module mem_fill_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_fill_arbiter_if.master bus,
    output logic [1:0]         dbg_state_o
);
    localparam int WORD_W = $clog2(WORDS);
    localparam int CNT_W  = WORD_W + 1;
    // byte-offset bits inside one block; cleared to form the block base
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(WORDS * 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_WORDS = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FILL_D = 2'd2,
        ST_FILL_I = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  recv_cnt_q;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              dwrite_ack_q;

    logic              in_fill;
    logic              issue_more;
    logic              fill_beat;
    logic              last_beat;
    logic [ADDR_W-1:0] issue_addr_d;
    logic [ADDR_W-1:0] dmiss_base_d;
    logic [ADDR_W-1:0] imiss_base_d;
    logic [CNT_W-1:0]  issue_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_d;

    // Fill bookkeeping: next issue address, beat qualification and counter increments.
    always_comb begin
        in_fill      = (state_q == ST_FILL_D) || (state_q == ST_FILL_I);
        issue_more   = issue_cnt_q < CNT_WORDS;
        // base is block aligned, so this sum never carries out of the block
        issue_addr_d = base_q + ADDR_W'({issue_cnt_q[WORD_W-1:0], 1'b0});
        // returns outside a fill (idle, write, or after a reset) are dropped here
        fill_beat    = in_fill && bus.mem_rvalid;
        last_beat    = fill_beat && (recv_cnt_q == CNT_LAST);
        dmiss_base_d = bus.dmiss_addr & ~OFF_MASK;
        imiss_base_d = bus.imiss_addr & ~OFF_MASK;
        issue_cnt_d  = issue_cnt_q + CNT_ONE;
        recv_cnt_d   = recv_cnt_q + CNT_ONE;
    end

    // Main FSM: request arbitration, memory command registers and fill counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            dwrite_ack_q <= 1'b0;
        end else begin
            // command and ack strobes are single-cycle unless re-armed below
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            dwrite_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.dwrite) begin
                        // the store goes out on the bus during the WRITE cycle itself
                        state_q      <= ST_WRITE;
                        mem_en_q     <= 1'b1;
                        mem_wr_q     <= 1'b1;
                        mem_addr_q   <= bus.dwrite_addr;
                        mem_wdata_q  <= bus.dwrite_data;
                        dwrite_ack_q <= 1'b1;
                    end else if (bus.dmiss) begin
                        state_q     <= ST_FILL_D;
                        base_q      <= dmiss_base_d;
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                    end else if (bus.imiss) begin
                        state_q     <= ST_FILL_I;
                        base_q      <= imiss_base_d;
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                    end
                end
                ST_WRITE: begin
                    // always back through IDLE so a held miss is re-arbitrated
                    state_q <= ST_IDLE;
                end
                ST_FILL_D, ST_FILL_I: begin
                    // one read per cycle until the whole block has been requested
                    if (issue_more) begin
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= issue_addr_d;
                        issue_cnt_q <= issue_cnt_d;
                    end
                    // completion is decided by returned words, not elapsed cycles
                    if (fill_beat) begin
                        recv_cnt_q <= recv_cnt_d;
                    end
                    if (last_beat) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // memory command outputs come straight from registers
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.dwrite_ack = dwrite_ack_q;

    // fill writes follow the return beat in the same cycle; zero when no beat
    assign bus.fill_data   = fill_beat ? bus.mem_rdata : '0;
    assign bus.fill_word   = fill_beat ? recv_cnt_q[WORD_W-1:0] : '0;
    assign bus.fill_we_d   = fill_beat && (state_q == ST_FILL_D);
    assign bus.fill_we_i   = fill_beat && (state_q == ST_FILL_I);
    assign bus.fill_done_d = last_beat && (state_q == ST_FILL_D);
    assign bus.fill_done_i = last_beat && (state_q == ST_FILL_I);
    assign bus.busy        = (state_q != ST_IDLE);
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency memory model.
`timescale 1ns/1ps
module tb_mem_fill_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 4;

  logic [15:0] exp_q[$];

  // memory return pipeline, slot 0 is what is presented this cycle
  logic        pv[16];
  logic [15:0] pa[16];

  mem_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) bus ();

  mem_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // one clock: capture this cycle's read, advance memory model, settle, sample
  task automatic tick();
    logic        v;
    logic [15:0] a;
    v = bus.mem_en && !bus.mem_wr;
    a = bus.mem_addr;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      pv[i] = pv[i+1];
      pa[i] = pa[i+1];
    end
    pv[15] = 1'b0;
    pa[15] = 16'h0;
    pv[lat-1] = v;
    pa[lat-1] = a;
    bus.mem_rvalid = pv[0];
    bus.mem_rdata  = pv[0] ? mem_f(pa[0]) : 16'hDEAD;
    #1;
    cyc++;
  endtask

  // follow one block fill to completion, checking issue and fill sequences
  task automatic wait_fill(input logic side_d, input logic [15:0] base, input int drop_after,
                           input int max_cyc, output int first_issue, output int done_at);
    int          n_issue;
    int          n_recv;
    logic        done_seen;
    logic        done;
    logic [15:0] e;
    n_issue     = 0;
    n_recv      = 0;
    done_seen   = 1'b0;
    first_issue = -1;
    done_at     = -1;
    exp_q.delete();
    for (int w = 0; w < 8; w++) exp_q.push_back(mem_f(base + 16'(2 * w)));
    for (int k = 0; k < max_cyc && !done_seen; k++) begin
      tick();
      if (bus.mem_en) begin
        if (first_issue < 0) first_issue = cyc;
        check_eq("issue_wr", 32'(bus.mem_wr), 0);
        check_eq("issue_addr", 32'(bus.mem_addr), 32'(base + 16'(2 * n_issue)));
        check_eq("issue_cyc", cyc - first_issue, n_issue);
        n_issue++;
      end
      done = side_d ? bus.fill_done_d : bus.fill_done_i;
      if (bus.fill_we_i || bus.fill_we_d) begin
        check_eq("we_side", 32'({bus.fill_we_d, bus.fill_we_i}), side_d ? 2 : 1);
        check_eq("fill_word", 32'(bus.fill_word), n_recv);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check_eq("fill_data", 32'(bus.fill_data), 32'(e));
        check_eq("fill_done", 32'(done), (n_recv == 7) ? 1 : 0);
        check_eq("done_other", 32'(side_d ? bus.fill_done_i : bus.fill_done_d), 0);
        n_recv++;
        if (n_recv == drop_after) begin
          if (side_d) bus.dmiss = 1'b0;
          else        bus.imiss = 1'b0;
        end
      end else begin
        check_eq("done_without_we", 32'(bus.fill_done_i | bus.fill_done_d), 0);
      end
      if (done) begin
        done_seen = 1'b1;
        done_at   = cyc;
      end
    end
    check_eq("fill_timeout", 32'(done_seen), 1);
    check_eq("issue_count", n_issue, 8);
    check_eq("recv_count", n_recv, 8);
    if (side_d) bus.dmiss = 1'b0;
    else        bus.imiss = 1'b0;
    tick();
    check_eq("idle_busy", 32'(bus.busy), 0);
    check_eq("idle_state", 32'(dbg_state), 0);
    check_eq("idle_mem_en", 32'(bus.mem_en), 0);
  endtask

  // stimulus
  initial begin
    int r, fi, da, fi2, da2, d_lat1, beats;
    bus.imiss = 0; bus.imiss_addr = 0;
    bus.dmiss = 0; bus.dmiss_addr = 0;
    bus.dwrite = 0; bus.dwrite_addr = 0; bus.dwrite_data = 0;
    bus.mem_rvalid = 0; bus.mem_rdata = 0;
    for (int i = 0; i < 16; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'h0;
    end

    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_state", 32'(dbg_state), 0);
    check_eq("rst_mem_en", 32'(bus.mem_en), 0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 0);
    check_eq("rst_fill_we", 32'({bus.fill_we_d, bus.fill_we_i}), 0);
    check_eq("rst_ack", 32'(bus.dwrite_ack), 0);
    rst = 0;
    tick();

    // single I fill, latency 4
    lat = 4;
    bus.imiss_addr = 16'h1236; bus.imiss = 1; r = cyc;
    wait_fill(1'b0, 16'h1230, -1, 60, fi, da);
    check_eq("t1_first_issue", fi, r + 2);
    check_eq("t1_done_cyc", da, r + 13);

    // simultaneous D and I miss, latency 3
    lat = 3;
    bus.dmiss_addr = 16'h4008; bus.dmiss = 1;
    bus.imiss_addr = 16'h0010; bus.imiss = 1; r = cyc;
    wait_fill(1'b1, 16'h4000, -1, 60, fi, da);
    check_eq("t2_d_first_issue", fi, r + 2);
    check_eq("t2_d_done_cyc", da, r + 12);
    wait_fill(1'b0, 16'h0010, -1, 60, fi2, da2);
    check_eq("t2_i_first_issue", fi2, da + 3);
    check_eq("t2_i_done_cyc", da2, fi2 + 10);

    // store together with D miss
    bus.dwrite_addr = 16'h2002; bus.dwrite_data = 16'hBEEF; bus.dwrite = 1;
    bus.dmiss_addr = 16'h3006; bus.dmiss = 1; r = cyc;
    tick();
    check_eq("t3_state", 32'(dbg_state), 1);
    check_eq("t3_mem_en", 32'(bus.mem_en), 1);
    check_eq("t3_mem_wr", 32'(bus.mem_wr), 1);
    check_eq("t3_addr", 32'(bus.mem_addr), 32'h2002);
    check_eq("t3_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    check_eq("t3_ack", 32'(bus.dwrite_ack), 1);
    bus.dwrite = 0;
    tick();
    check_eq("t3_idle_busy", 32'(bus.busy), 0);
    check_eq("t3_ack_pulse", 32'(bus.dwrite_ack), 0);
    check_eq("t3_idle_mem_en", 32'(bus.mem_en), 0);
    wait_fill(1'b1, 16'h3000, -1, 60, fi, da);
    check_eq("t3_fill_first_issue", fi, r + 4);
    check_eq("t3_fill_done_cyc", da, r + 14);

    // reset during the 5th issue cycle
    lat = 4;
    bus.imiss_addr = 16'h5000; bus.imiss = 1; r = cyc;
    while (cyc < r + 6) tick();
    rst = 1;
    #1;
    check_eq("t4_mem_en", 32'(bus.mem_en), 0);
    check_eq("t4_busy", 32'(bus.busy), 0);
    check_eq("t4_state", 32'(dbg_state), 0);
    check_eq("t4_fill_we", 32'({bus.fill_we_d, bus.fill_we_i}), 0);
    check_eq("t4_fill_data", 32'(bus.fill_data), 0);
    check_eq("t4_fill_word", 32'(bus.fill_word), 0);
    check_eq("t4_mem_addr", 32'(bus.mem_addr), 0);
    bus.imiss = 0;
    beats = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 1) rst = 0;
      if (bus.mem_rvalid) beats++;
      check_eq("t4_stray_we", 32'({bus.fill_we_d, bus.fill_we_i, bus.fill_done_i}), 0);
    end
    check_eq("t4_stray_beats", beats, 3);
    bus.imiss_addr = 16'h6000; bus.imiss = 1; r = cyc;
    wait_fill(1'b0, 16'h6000, -1, 60, fi, da);
    check_eq("t4_refill_done_cyc", da, r + 13);

    // latency 1 versus 10 at the top of the address space
    lat = 1;
    bus.imiss_addr = 16'hFFF0; bus.imiss = 1; r = cyc;
    wait_fill(1'b0, 16'hFFF0, -1, 60, fi, da);
    check_eq("t5_lat1_done", da - r, 10);
    d_lat1 = da - r;
    lat = 10;
    bus.imiss_addr = 16'hFFF0; bus.imiss = 1; r = cyc;
    wait_fill(1'b0, 16'hFFF0, -1, 80, fi, da);
    check_eq("t5_lat10_done", da - r, 19);
    check_eq("t5_shift", (da - r) - d_lat1, 9);

    // requester drops imiss after two returned words
    lat = 2;
    bus.imiss_addr = 16'h7004; bus.imiss = 1; r = cyc;
    wait_fill(1'b0, 16'h7000, 2, 60, fi, da);
    check_eq("t6_done_cyc", da, r + 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
